ddr_req_queue: RTL and testbench
================================

DDR_REQ_QUEUE -- requirements
Module: ddr_req_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 15, max WAIT cycles before abandoning a handshake.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 host_valid  input  1  host request present.
REQ-006 host_rw  input  1  1 = write, 0 = read.
REQ-007 host_addr  input  32  request address.
REQ-008 host_data  input  64  write data (don't-care for reads).
REQ-009 host_ready  output  1  queue can accept; equals !q_full.
REQ-010 next_cmd  input  1  controller idle / ready for next activate.
REQ-011 act_cmd  output  1  one-cycle issue strobe to controller.
REQ-012 cmd_rw, cmd_addr, cmd_data  output  1/32/64  head entry issued; held until next issue.
REQ-013 q_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 q_full, q_empty  output  1  occupancy == DEPTH / == 0.
REQ-015 issue_err  output  1  sticky; set on handshake timeout.

Function
REQ-016 Push SHALL occur on an edge where host_valid && host_ready; entry {rw,addr,data} written at write pointer.
REQ-017 Storage SHALL be a circular buffer; read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-019 IDLE: if !q_empty && next_cmd, SHALL register head into cmd_*, set act_cmd=1, pop head, go ISSUE; else stay.
REQ-020 ISSUE: SHALL last exactly one cycle, clear act_cmd, clear wait timer, go WAIT.
REQ-021 WAIT: if !next_cmd, go IDLE; else increment timer; when timer reaches TIMEOUT, set issue_err, go IDLE.
REQ-022 act_cmd SHALL never be high two consecutive cycles.
REQ-023 Minimum latency: request accepted on edge E into empty queue with next_cmd high -> act_cmd high in cycle after edge E+1.
REQ-024 Simultaneous push and pop SHALL leave q_count unchanged; both pointers advance.
REQ-025 When full, host_ready SHALL be 0 even if a pop occurs that cycle (no same-cycle push on full).
REQ-026 Requests SHALL issue in strict FIFO order; no reordering by rw.
REQ-027 q_count arithmetic SHALL never wrap: no push when full, no pop when empty.

Reset
REQ-028 On reset: pointers=0, q_count=0, q_empty=1, q_full=0, host_ready=1, state=IDLE, act_cmd=0, cmd_rw=0, cmd_addr=0, cmd_data=0, issue_err=0, timer=0.
REQ-029 Reset mid-handshake (ISSUE/WAIT) SHALL discard all queued entries and drop act_cmd the following cycle.
REQ-030 Storage array contents need not be reset.

Configuration
REQ-031 Macro DDR_REQ_QUEUE_STATS_EN: when defined, module SHALL add outputs wr_issued and rd_issued (16 bits each), incremented on each act_cmd by cmd_rw, saturating at 16'hFFFF, cleared by reset.
REQ-032 Without DDR_REQ_QUEUE_STATS_EN the ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-033 Single write: reset, next_cmd=1, push {rw=1, addr=32'h0000_0040, data=64'hA5A5} -> act_cmd pulse in cycle after edge E+1, cmd_addr=32'h40, q_empty=1 after.
REQ-034 Fill: next_cmd=0, push 8 requests -> q_full=1, host_ready=0, q_count=8; 9th request not accepted; raise next_cmd/drop per handshake -> 8 issues in order, addresses match push order.
REQ-035 Simultaneous push/pop at q_count=3 -> q_count stays 3; wrap past entry 7 -> order preserved.
REQ-036 Timeout: one entry, next_cmd held 1 permanently -> act_cmd pulse, 15 WAIT cycles, issue_err=1 and stays 1; queue empty.
REQ-037 Reset in WAIT with 4 queued -> next cycle q_count=0, act_cmd=0, state IDLE, issue_err=0.
REQ-038 With DDR_REQ_QUEUE_STATS_EN: 3 writes + 2 reads issued -> wr_issued=3, rd_issued=2.

Source files
------------

// File: rtl/ddr_req_queue_if.sv
// rtl/ddr_req_queue_if.sv - host request channel into the DDR request queue
interface ddr_req_queue_if;
  logic        host_valid;
  logic        host_rw;
  logic [31:0] host_addr;
  logic [63:0] host_data;
  logic        host_ready;

  modport master (
    output host_valid, host_rw, host_addr, host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid, host_rw, host_addr, host_data,
    output host_ready
  );
endinterface

// File: rtl/ddr_req_queue.sv
// rtl/ddr_req_queue.sv - FIFO of host DDR requests issued one at a time via an IDLE/ISSUE/WAIT handshake
// Optional macro DDR_REQ_QUEUE_STATS_EN adds saturating wr_issued/rd_issued counters.
module ddr_req_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  ddr_req_queue_if.slave         host,
  input  logic                   next_cmd,
  output logic                   act_cmd,
  output logic                   cmd_rw,
  output logic [31:0]            cmd_addr,
  output logic [63:0]            cmd_data,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_full,
  output logic                   q_empty,
  output logic                   issue_err
`ifdef DDR_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]            wr_issued,
  output logic [15:0]            rd_issued
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            issue_err_q, issue_err_d;
  logic            cmd_rw_q, cmd_rw_d;
  logic [31:0]     cmd_addr_q, cmd_addr_d;
  logic [63:0]     cmd_data_q, cmd_data_d;
  logic [96:0]     mem_q [DEPTH];
  logic [96:0]     head;
  logic            full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Full blocks the push outright, even when a pop frees a slot this cycle.
  assign push  = host.host_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      issue_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      issue_err_q <= issue_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    issue_err_d = issue_err_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && next_cmd) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!next_cmd) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (timer_d == TW'(TIMEOUT)) begin
            issue_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    act_cmd         = (state_q == ISSUE);
    host.host_ready = !full;
    q_full          = full;
    q_empty         = empty;
    q_count         = count_q;
    issue_err       = issue_err_q;
    cmd_rw          = cmd_rw_q;
    cmd_addr        = cmd_addr_q;
    cmd_data        = cmd_data_q;
  end

  // Power-of-two depth lets the pointers wrap DEPTH-1 -> 0 by plain overflow.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
    cmd_rw_d   = pop ? head[96]    : cmd_rw_q;
    cmd_addr_d = pop ? head[95:64] : cmd_addr_q;
    cmd_data_d = pop ? head[63:0]  : cmd_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_rw_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_rw_q   <= cmd_rw_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= {host.host_rw, host.host_addr, host.host_data};
  end

`ifdef DDR_REQ_QUEUE_STATS_EN
  logic [15:0] wr_issued_q, rd_issued_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_issued_q <= '0;
      rd_issued_q <= '0;
    end else if (act_cmd) begin
      if (cmd_rw_q && wr_issued_q != 16'hFFFF)
        wr_issued_q <= wr_issued_q + 16'd1;
      if (!cmd_rw_q && rd_issued_q != 16'hFFFF)
        rd_issued_q <= rd_issued_q + 16'd1;
    end
  end

  assign wr_issued = wr_issued_q;
  assign rd_issued = rd_issued_q;
`endif

endmodule

// File: tb/tb_ddr_req_queue.sv
// tb/tb_ddr_req_queue.sv - directed self-checking bench for ddr_req_queue
module tb_ddr_req_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic        next_cmd;
  logic        act_cmd, cmd_rw, q_full, q_empty, issue_err;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [3:0]  q_count;
`ifdef DDR_REQ_QUEUE_STATS_EN
  logic [15:0] wr_issued, rd_issued;
`endif
  int checks = 0;
  int errors = 0;

  ddr_req_queue_if hif ();

  ddr_req_queue #(.DEPTH(8), .TIMEOUT(15)) dut (
    .clock     (clock),
    .reset     (reset),
    .host      (hif),
    .next_cmd  (next_cmd),
    .act_cmd   (act_cmd),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .q_count   (q_count),
    .q_full    (q_full),
    .q_empty   (q_empty),
    .issue_err (issue_err)
`ifdef DDR_REQ_QUEUE_STATS_EN
    ,
    .wr_issued (wr_issued),
    .rd_issued (rd_issued)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic rw, input logic [31:0] a, input logic [63:0] d);
    hif.host_valid = 1'b1;
    hif.host_rw    = rw;
    hif.host_addr  = a;
    hif.host_data  = d;
    step();
    hif.host_valid = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] a, input logic rw);
    int n = 0;
    next_cmd = 1'b1;
    do begin
      step();
      n++;
    end while (!act_cmd && n < 20);
    chk({tag, "_act"}, act_cmd, 1);
    chk({tag, "_addr"}, cmd_addr, a);
    chk({tag, "_rw"}, cmd_rw, rw);
    next_cmd = 1'b0;
    step();
    chk({tag, "_act_drop"}, act_cmd, 0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    next_cmd = 1'b0;
    hif.host_valid = 1'b0;
    hif.host_rw = 1'b0;
    hif.host_addr = '0;
    hif.host_data = '0;
    step();
    step();
    chk("rst_count", q_count, 0);
    chk("rst_empty", q_empty, 1);
    chk("rst_full", q_full, 0);
    chk("rst_ready", hif.host_ready, 1);
    chk("rst_act", act_cmd, 0);
    chk("rst_cmd", {cmd_rw, cmd_addr}, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_err", issue_err, 0);
    reset = 1'b0;

    // single write, minimum latency
    next_cmd = 1'b1;
    push_req(1'b1, 32'h40, 64'hA5A5);
    chk("w1_count", q_count, 1);
    chk("w1_act_early", act_cmd, 0);
    step();
    chk("w1_act", act_cmd, 1);
    chk("w1_addr", cmd_addr, 32'h40);
    chk("w1_data", cmd_data, 64'hA5A5);
    chk("w1_rw", cmd_rw, 1);
    chk("w1_empty", q_empty, 1);
    next_cmd = 1'b0;
    step();
    chk("w1_act_once", act_cmd, 0);
    step();

    // fill to DEPTH, 9th refused, drain in order
    for (int i = 0; i < 8; i++) push_req(i[0], 32'h100 + 32'(i * 4), 64'(i));
    hif.host_valid = 1'b1;
    hif.host_addr = 32'h999;
    chk("fill_full", q_full, 1);
    chk("fill_ready", hif.host_ready, 0);
    chk("fill_count", q_count, 8);
    step();
    hif.host_valid = 1'b0;
    chk("fill_9th", q_count, 8);
    for (int i = 0; i < 8; i++) expect_issue($sformatf("fill%0d", i), 32'h100 + 32'(i * 4), i[0]);
    chk("fill_empty", q_empty, 1);

    // simultaneous push/pop at count 3, then wrap past entry 7
    for (int i = 0; i < 3; i++) push_req(1'b0, 32'h200 + 32'(i * 4), 64'(i));
    next_cmd = 1'b1;
    push_req(1'b1, 32'h20C, 64'h3);
    chk("pp_count", q_count, 3);
    chk("pp_act", act_cmd, 1);
    chk("pp_addr", cmd_addr, 32'h200);
    next_cmd = 1'b0;
    step();
    step();
    for (int i = 4; i < 9; i++) push_req(1'b0, 32'h200 + 32'(i * 4), 64'(i));
    chk("wrap_full", q_count, 8);
    // pop while full: the push must still be refused
    hif.host_valid = 1'b1;
    hif.host_addr = 32'hBAD;
    next_cmd = 1'b1;
    chk("fullpop_ready", hif.host_ready, 0);
    step();
    hif.host_valid = 1'b0;
    chk("fullpop_count", q_count, 7);
    chk("fullpop_addr", cmd_addr, 32'h204);
    next_cmd = 1'b0;
    step();
    step();
    expect_issue("wrap_208", 32'h208, 1'b0);
    expect_issue("wrap_20c", 32'h20C, 1'b1);
    for (int i = 4; i < 9; i++) expect_issue($sformatf("wrap%0d", i), 32'h200 + 32'(i * 4), 1'b0);
    chk("wrap_empty", q_empty, 1);

    // timeout with next_cmd stuck high
    push_req(1'b0, 32'h300, 64'h0);
    next_cmd = 1'b1;
    step();
    chk("to_act", act_cmd, 1);
    step();
    for (int i = 0; i < 14; i++) step();
    chk("to_err_before", issue_err, 0);
    step();
    chk("to_err_set", issue_err, 1);
    step();
    step();
    chk("to_err_sticky", issue_err, 1);
    chk("to_act_low", act_cmd, 0);
    chk("to_empty", q_empty, 1);

    // reset while in WAIT with 4 queued
    next_cmd = 1'b0;
    for (int i = 0; i < 5; i++) push_req(1'b1, 32'h400 + 32'(i * 4), 64'(i));
    next_cmd = 1'b1;
    step();
    chk("rw_act", act_cmd, 1);
    step();
    chk("rw_count", q_count, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_count0", q_count, 0);
    chk("rw_act0", act_cmd, 0);
    chk("rw_err0", issue_err, 0);
    chk("rw_addr0", cmd_addr, 0);
    push_req(1'b0, 32'h500, 64'h5);
    step();
    chk("rw_idle_issue", act_cmd, 1);
    chk("rw_idle_addr", cmd_addr, 32'h500);
    next_cmd = 1'b0;
    step();
    step();

`ifdef DDR_REQ_QUEUE_STATS_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("st_rst", {wr_issued, rd_issued}, 0);
    push_req(1'b1, 32'h600, 64'h0);
    push_req(1'b0, 32'h604, 64'h0);
    push_req(1'b1, 32'h608, 64'h0);
    push_req(1'b0, 32'h60C, 64'h0);
    push_req(1'b1, 32'h610, 64'h0);
    expect_issue("st0", 32'h600, 1'b1);
    expect_issue("st1", 32'h604, 1'b0);
    expect_issue("st2", 32'h608, 1'b1);
    expect_issue("st3", 32'h60C, 1'b0);
    expect_issue("st4", 32'h610, 1'b1);
    chk("st_wr", wr_issued, 3);
    chk("st_rd", rd_issued, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
